// File: rtl/clk_div_multi_pkg.sv
// Shared definitions for the multi-channel clock divider: defaults and channel FSM states.
package clk_div_multi_pkg;

    // 25 bits hold a 25_000_000-cycle half-period (50 MHz -> 1 Hz).
    localparam int unsigned DEF_CNT_W = 25;
    localparam int unsigned DEF_HALF  = 25_000_000;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } div_state_e;

    // A zero half-period parks the channel.
    function automatic div_state_e state_for_half(input logic is_zero);
        return is_zero ? ST_HALT : ST_RUN;
    endfunction

endpackage

// File: rtl/clk_div_multi_channel.sv
// One divider channel: half-period counter, active/pending half regs, HALT/RUN FSM,
// registered 50% duty clock and rising-edge tick.
module clk_div_multi_channel
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend_val;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;

    logic             w_term;
    logic             w_has_new;
    logic [CNT_W-1:0] w_new_half;
    logic             w_new_zero;

    // A load landing on the applying edge wins over the stored pending value.
    assign w_term     = (r_cnt == (r_half - CNT_W'(1)));
    assign w_has_new  = i_load | r_pend;
    assign w_new_half = i_load ? i_value : r_pend_val;
    assign w_new_zero = (w_new_half == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= state_for_half(CNT_W'(DEFAULT_HALF) == '0);
            r_cnt      <= '0;
            r_half     <= CNT_W'(DEFAULT_HALF);
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_load) begin
                r_pend_val <= i_value;
                r_pend     <= 1'b1;
            end

            if (i_sync) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_pend <= 1'b0;
                if (w_has_new) begin
                    r_half  <= w_new_half;
                    r_state <= state_for_half(w_new_zero);
                end
            end else begin
                case (r_state)
                    ST_HALT: begin
                        // Apply the stored value; a same-cycle load becomes the next pending value.
                        if (r_pend) begin
                            r_half  <= r_pend_val;
                            r_state <= state_for_half(r_pend_val == '0);
                            r_cnt   <= '0;
                            r_clk   <= 1'b0;
                            r_pend  <= i_load;
                        end
                    end
                    ST_RUN: begin
                        if (i_en) begin
                            if (w_term) begin
                                r_cnt <= '0;
                                if (w_has_new) begin
                                    r_half <= w_new_half;
                                    r_pend <= 1'b0;
                                end
                                if (w_has_new && w_new_zero) begin
                                    r_clk   <= 1'b0;
                                    r_state <= ST_HALT;
                                end else begin
                                    r_clk  <= ~r_clk;
                                    r_tick <= ~r_clk;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= ST_HALT;
                endcase
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider top: channel-select decode and enable/sync fan-out.
// Optional feature macro: CLK_DIV_SYNC_EN adds the Div_Sync phase-align strobe.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CH_W         = 1,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
    input  logic              Clk_In,
    input  logic              Div_Rst_n,
    input  logic              Div_En,
    input  logic              Div_Load,
    input  logic [CH_W-1:0]   Div_Ch_Sel,
    input  logic [CNT_W-1:0]  Div_Value,
`ifdef CLK_DIV_SYNC_EN
    input  logic              Div_Sync,
`endif
    output logic [NUM_CH-1:0] Clk_Out,
    output logic [NUM_CH-1:0] Tick_Out,
    output logic [NUM_CH-1:0] Div_Pend
);

    logic w_sync;

`ifdef CLK_DIV_SYNC_EN
    assign w_sync = Div_Sync;
`else
    assign w_sync = 1'b0;
`endif

    // Selects at or above NUM_CH match no channel, so such loads are dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_load;
        assign w_load = Div_Load && (Div_Ch_Sel == CH_W'(gi));

        clk_div_multi_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk     (Clk_In),
            .rst_n   (Div_Rst_n),
            .i_en    (Div_En),
            .i_load  (w_load),
            .i_value (Div_Value),
            .i_sync  (w_sync),
            .o_clk   (Clk_Out[gi]),
            .o_tick  (Tick_Out[gi]),
            .o_pend  (Div_Pend[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic against a
// cycles-remaining reference model. Define CLK_DIV_SYNC_EN to cover Div_Sync.
module tb_clk_div_multi;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DEF    = 5;

    logic              Clk_In;
    logic              Div_Rst_n;
    logic              Div_En;
    logic              Div_Load;
    logic [CH_W-1:0]   Div_Ch_Sel;
    logic [CNT_W-1:0]  Div_Value;
    logic              Div_Sync;
    logic [NUM_CH-1:0] Clk_Out;
    logic [NUM_CH-1:0] Tick_Out;
    logic [NUM_CH-1:0] Div_Pend;

    clk_div_multi #(
        .NUM_CH       (NUM_CH),
        .CH_W         (CH_W),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEF)
    ) dut (
        .Clk_In     (Clk_In),
        .Div_Rst_n  (Div_Rst_n),
        .Div_En     (Div_En),
        .Div_Load   (Div_Load),
        .Div_Ch_Sel (Div_Ch_Sel),
        .Div_Value  (Div_Value),
`ifdef CLK_DIV_SYNC_EN
        .Div_Sync   (Div_Sync),
`endif
        .Clk_Out    (Clk_Out),
        .Tick_Out   (Tick_Out),
        .Div_Pend   (Div_Pend)
    );

    initial Clk_In = 1'b1;
    always #10 Clk_In = ~Clk_In;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each channel's active half, pending value, edges left until the
    // next toggle, and the expected output levels.
    int unsigned m_half [NUM_CH];
    int unsigned m_rem  [NUM_CH];
    int unsigned m_pval [NUM_CH];
    bit          m_pend [NUM_CH];
    bit          m_clk  [NUM_CH];
    bit          m_tick [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_half[c] = DEF; m_rem[c] = DEF; m_pval[c] = 0;
            m_pend[c] = 0;   m_clk[c] = 0;   m_tick[c] = 0;
        end
    endtask

    task automatic model_edge(input bit en, input bit load, input int unsigned sel,
                              input int unsigned val, input bit sync);
        for (int c = 0; c < NUM_CH; c++) begin
            bit ld;
            ld = load && (sel == c);
            m_tick[c] = 0;
            if (sync) begin
                if (ld) m_half[c] = val;
                else if (m_pend[c]) m_half[c] = m_pval[c];
                m_pend[c] = 0; m_clk[c] = 0; m_rem[c] = m_half[c];
            end else if (m_half[c] == 0) begin
                if (m_pend[c]) begin
                    m_half[c] = m_pval[c]; m_rem[c] = m_pval[c];
                    m_clk[c] = 0; m_pend[c] = 0;
                end
                if (ld) begin m_pend[c] = 1; m_pval[c] = val; end
            end else if (!en) begin
                if (ld) begin m_pend[c] = 1; m_pval[c] = val; end
            end else begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    if (ld || m_pend[c]) begin
                        m_half[c] = ld ? val : m_pval[c];
                        m_pend[c] = 0;
                        ld = 0;
                    end
                    if (m_half[c] == 0) m_clk[c] = 0;
                    else begin
                        m_clk[c]  = !m_clk[c];
                        m_tick[c] = m_clk[c];
                        m_rem[c]  = m_half[c];
                    end
                end
                if (ld) begin m_pend[c] = 1; m_pval[c] = val; end
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
        for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c] = m_clk[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
        end
        check({tag, ".clk"},  32'(Clk_Out),  32'(e_clk));
        check({tag, ".tick"}, 32'(Tick_Out), 32'(e_tick));
        check({tag, ".pend"}, 32'(Div_Pend), 32'(e_pend));
    endtask

    // One clock: drive inputs, step the model on the edge, sample 1 ns later.
    task automatic cyc(input string tag, input bit en, input bit load, input int unsigned sel,
                       input int unsigned val, input bit sync);
        Div_En     = en;
        Div_Load   = load;
        Div_Ch_Sel = CH_W'(sel);
        Div_Value  = CNT_W'(val);
        Div_Sync   = sync;
        @(posedge Clk_In);
        model_edge(en, load, sel, val, sync);
        #1;
        compare_outputs(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cyc(tag, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        Div_Rst_n = 1'b0; Div_En = 1'b1; Div_Load = 1'b0;
        Div_Ch_Sel = '0;  Div_Value = '0; Div_Sync = 1'b0;
        model_reset();
        #5;
        check("rst.clk",  32'(Clk_Out),  32'd0);
        check("rst.tick", 32'(Tick_Out), 32'd0);
        check("rst.pend", 32'(Div_Pend), 32'd0);
        #5 Div_Rst_n = 1'b1;

        // Default half: first rise 5 edges after release, period 10.
        run("dflt", 25);

        // Mid-period reload: half 4, then load 2 while the count is 1.
        cyc("ld4", 1'b1, 1'b1, 0, 4, 1'b0);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_half[0] == 4 && m_pend[0] == 0 && m_rem[0] == 3) found = 1;
            else run("ld4w", 1);
        end
        check("ld4.reached", 32'(found), 32'd1);
        cyc("ld2", 1'b1, 1'b1, 0, 2, 1'b0);
        run("ld2r", 20);

        // Halt then restart at half 3.
        cyc("halt", 1'b1, 1'b1, 0, 0, 1'b0);
        run("haltr", 12);
        check("halt.half", 32'(m_half[0]), 32'd0);
        cyc("rst3", 1'b1, 1'b1, 0, 3, 1'b0);
        run("rst3r", 15);

        // Enable low for 7 cycles mid-count.
        run("pre_en", 2);
        for (int k = 0; k < 7; k++) cyc("en0", 1'b0, 1'b0, 0, 0, 1'b0);
        run("en1", 12);

        // Out-of-range select is ignored.
        cyc("badsel", 1'b1, 1'b1, 3, 7, 1'b0);
        run("badselr", 15);

        // Coincident load on a pending channel and last-write-wins.
        cyc("lw1", 1'b1, 1'b1, 1, 6, 1'b0);
        cyc("lw2", 1'b1, 1'b1, 1, 2, 1'b0);
        run("lwr", 20);

`ifdef CLK_DIV_SYNC_EN
        cyc("s0", 1'b1, 1'b1, 0, 3, 1'b0);
        run("s0r", 4);
        cyc("s1", 1'b1, 1'b1, 1, 3, 1'b0);
        run("s1r", 7);
        cyc("sync", 1'b0, 1'b0, 0, 0, 1'b1);
        run("syncr", 14);
`endif

        for (int k = 0; k < 600; k++) begin
            bit sy;
`ifdef CLK_DIV_SYNC_EN
            sy = ($urandom % 40) == 0;
`else
            sy = 1'b0;
`endif
            cyc("rnd", ($urandom % 8) != 0, ($urandom % 6) == 0,
                $urandom % 4, $urandom % 7, sy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
